mem_access: RTL and testbench

Memory-access pipeline stage between the EX/MEM latch and the MEM/WB latch. It executes RV32I loads and stores as byte-serial transactions on the shared 8-bit memory arbiter port. It assembles and sign- or zero-extends load results and raises a stall request for as long as an access is in flight. Non-memory instructions pass through combinationally with no added latency.

---
 rtl/mem_access.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access pipeline stage sitting between the EX/MEM and MEM/WB latches.
// RV32I loads and stores are executed as byte-serial transactions on a shared
// 8-bit arbiter port. Load bytes are assembled little-endian and sign- or
// zero-extended. stall_req is held high while an access is in flight.
// Non-memory instructions pass straight through with no added latency.
//
// Optional feature macro: MEM_FWD_EN
//    When defined, the fwd_valid / fwd_reg_addr / fwd_reg_data ports and the
//    forwarding logic towards ID are built. When undefined they are omitted.
//
// Ports
//    clk_in, rst_in, rdy_in    clock, async active-high reset, global ready
//    ex_*                      instruction fields from the EX/MEM latch
//    mem_req/wr/addr/wdata     byte request towards the memory arbiter
//    mem_gnt, mem_rdata        grant and read byte (byte valid one cycle
//                              after its grant)
//    stall_req                 pipeline stall request to stall control
//    mem_reg_addr_out,
//    mem_reg_data_out,
//    if_write_out              write-back fields to the MEM/WB latch
//    fwd_*                     forwarding to ID (MEM_FWD_EN only)
// -----------------------------------------------------------------------------
module mem_access #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [4:0]        ex_reg_addr,
   input  logic [31:0]       ex_reg_data,
   input  logic              ex_if_write,
   input  logic [3:0]        ex_mem_op,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [31:0]       ex_store_data,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_gnt,
   input  logic [7:0]        mem_rdata,
   output logic              stall_req,
   output logic [4:0]        mem_reg_addr_out,
   output logic [31:0]       mem_reg_data_out,
   output logic              if_write_out
`ifdef MEM_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [4:0]        fwd_reg_addr,
   output logic [31:0]       fwd_reg_data
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_XFER      = 2'd1,
      ST_WAIT_LAST = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   function automatic logic op_is_load(input logic [3:0] op);
      op_is_load = (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      op_is_store = (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Number of bytes moved by an access.
   function automatic logic [2:0] op_bytes(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
         OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
         OP_LW, OP_SW:         op_bytes = 3'd4;
         default:              op_bytes = 3'd1;
      endcase
   endfunction

   // Sign/zero extension of the assembled load result.
   function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [31:0] r);
      case (op)
         OP_LB:   load_extend = {{24{r[7]}}, r[7:0]};
         OP_LH:   load_extend = {{16{r[15]}}, r[15:0]};
         OP_LBU:  load_extend = {24'd0, r[7:0]};
         OP_LHU:  load_extend = {16'd0, r[15:0]};
         default: load_extend = r;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       sdata_q, sdata_d;
   logic [4:0]        rd_q, rd_d;
   logic              wen_q, wen_d;
   logic [2:0]        n_q, n_d;
   logic [1:0]        k_q, k_d;
   logic [31:0]       result_q, result_d;
   // A read byte granted last cycle is returning now; rd_idx_q says where it goes.
   logic              rd_pend_q, rd_pend_d;
   logic [1:0]        rd_idx_q, rd_idx_d;

   logic              is_mem_op_s;
   logic              last_byte_s;

   assign is_mem_op_s = op_is_load(ex_mem_op) || op_is_store(ex_mem_op);
   assign last_byte_s = ({1'b0, k_q} == (n_q - 3'd1));

   // Next-state, per-access registers and read-byte capture.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      sdata_d   = sdata_q;
      rd_d      = rd_q;
      wen_d     = wen_q;
      n_d       = n_q;
      k_d       = k_q;
      result_d  = result_q;
      rd_pend_d = 1'b0;
      rd_idx_d  = rd_idx_q;

      // Capture is independent of rdy_in: the byte was already granted.
      if (rd_pend_q) begin
         result_d[{rd_idx_q, 3'b000} +: 8] = mem_rdata;
      end else begin
         result_d = result_q;
      end

      if (rdy_in) begin
         case (state_q)
            ST_IDLE: begin
               if (is_mem_op_s) begin
                  op_d     = ex_mem_op;
                  addr_d   = ex_mem_addr;
                  sdata_d  = ex_store_data;
                  rd_d     = ex_reg_addr;
                  wen_d    = ex_if_write && op_is_load(ex_mem_op);
                  n_d      = op_bytes(ex_mem_op);
                  k_d      = 2'd0;
                  result_d = 32'd0;
                  state_d  = ST_XFER;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_XFER: begin
               if (mem_gnt) begin
                  rd_pend_d = !op_is_store(op_q);
                  rd_idx_d  = k_q;
                  k_d       = k_q + 2'd1;
                  if (last_byte_s) begin
                     state_d = op_is_store(op_q) ? ST_DONE : ST_WAIT_LAST;
                  end else begin
                     state_d = ST_XFER;
                  end
               end else begin
                  state_d = ST_XFER;
               end
            end
            ST_WAIT_LAST: state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output decode: arbiter request, stall and write-back/forwarding fields.
   always_comb begin
      mem_req          = 1'b0;
      mem_wr           = 1'b0;
      mem_addr         = '0;
      mem_wdata        = 8'd0;
      stall_req        = 1'b0;
      mem_reg_addr_out = 5'd0;
      mem_reg_data_out = 32'd0;
      if_write_out     = 1'b0;
`ifdef MEM_FWD_EN
      fwd_valid        = 1'b0;
`endif
      if (rst_in) begin
         stall_req = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               mem_reg_addr_out = ex_reg_addr;
               mem_reg_data_out = ex_reg_data;
               if (is_mem_op_s) begin
                  stall_req    = 1'b1;
                  if_write_out = 1'b0;
               end else begin
                  if_write_out = ex_if_write;
`ifdef MEM_FWD_EN
                  fwd_valid    = ex_if_write && (ex_reg_addr != 5'd0);
`endif
               end
            end
            ST_XFER: begin
               stall_req = 1'b1;
               mem_req   = rdy_in;
               mem_wr    = op_is_store(op_q);
               mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
               if (op_is_store(op_q)) begin
                  mem_wdata = sdata_q[{k_q, 3'b000} +: 8];
               end else begin
                  mem_wdata = 8'd0;
               end
            end
            ST_WAIT_LAST: stall_req = 1'b1;
            ST_DONE: begin
               mem_reg_addr_out = rd_q;
               mem_reg_data_out = load_extend(op_q, result_q);
               if_write_out     = wen_q;
`ifdef MEM_FWD_EN
               fwd_valid        = op_is_load(op_q) && (rd_q != 5'd0);
`endif
            end
            default: stall_req = 1'b0;
         endcase
      end
`ifdef MEM_FWD_EN
      fwd_reg_addr = mem_reg_addr_out;
      fwd_reg_data = mem_reg_data_out;
`endif
   end

   // State and per-access registers; reset abandons any access in flight.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         op_q      <= 4'd0;
         addr_q    <= '0;
         sdata_q   <= 32'd0;
         rd_q      <= 5'd0;
         wen_q     <= 1'b0;
         n_q       <= 3'd0;
         k_q       <= 2'd0;
         result_q  <= 32'd0;
         rd_pend_q <= 1'b0;
         rd_idx_q  <= 2'd0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         sdata_q   <= sdata_d;
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         n_q       <= n_d;
         k_q       <= k_d;
         result_q  <= result_d;
         rd_pend_q <= rd_pend_d;
         rd_idx_q  <= rd_idx_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access: directed self-checking bench for mem_access. A small byte
// memory model answers granted reads one cycle later and logs granted
// addresses and write bytes. Inputs change on the falling edge; outputs are
// sampled 1 ns after it.
// -----------------------------------------------------------------------------
module tb_mem_access;
   localparam int ADDR_W = 32;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              rdy_in;
   logic [4:0]        ex_reg_addr;
   logic [31:0]       ex_reg_data;
   logic              ex_if_write;
   logic [3:0]        ex_mem_op;
   logic [ADDR_W-1:0] ex_mem_addr;
   logic [31:0]       ex_store_data;
   logic              mem_req;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_gnt;
   logic [7:0]        mem_rdata = 8'h00;
   logic              stall_req;
   logic [4:0]        mem_reg_addr_out;
   logic [31:0]       mem_reg_data_out;
   logic              if_write_out;
`ifdef MEM_FWD_EN
   logic              fwd_valid;
   logic [4:0]        fwd_reg_addr;
   logic [31:0]       fwd_reg_data;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]        mem_model [0:1023];
   logic [ADDR_W-1:0] addr_log [$];
   logic [7:0]        wdata_log [$];
   int                req_count = 0;

   mem_access #(.ADDR_W(ADDR_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .ex_reg_addr(ex_reg_addr), .ex_reg_data(ex_reg_data), .ex_if_write(ex_if_write),
      .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .stall_req(stall_req),
      .mem_reg_addr_out(mem_reg_addr_out), .mem_reg_data_out(mem_reg_data_out),
      .if_write_out(if_write_out)
`ifdef MEM_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_reg_addr(fwd_reg_addr), .fwd_reg_data(fwd_reg_data)
`endif
   );

   always #5 clk_in = ~clk_in;

   // Memory model: read byte returns one cycle after grant, 0 otherwise.
   always @(posedge clk_in) begin
      if (mem_req) req_count <= req_count + 1;
      if (mem_req && mem_gnt) begin
         addr_log.push_back(mem_addr);
         if (mem_wr) wdata_log.push_back(mem_wdata);
      end
      mem_rdata <= (mem_req && mem_gnt && !mem_wr) ? mem_model[mem_addr[9:0]] : 8'h00;
   end

   // Steps cycles until stall_req drops (bounded); returns the cycle number reached.
   task automatic run_until_done(input int start, output int cyc);
      cyc = start;
      do begin
         @(negedge clk_in); #1;
         cyc++;
      end while (stall_req !== 1'b0 && cyc < start + 40);
   endtask

   task automatic test_reset;
      @(negedge clk_in);
      ex_mem_op = 4'd3; ex_reg_addr = 5'd7; ex_reg_data = 32'hDEAD; ex_if_write = 1'b1;
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall_req); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
      checks++; if (mem_reg_data_out !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_reg_data_out); end
      checks++; if (mem_reg_addr_out !== 5'd0 || if_write_out !== 1'b0) begin errors++; $display("FAIL reset_wb got=%0d/%0b exp=0/0", mem_reg_addr_out, if_write_out); end
      ex_mem_op = 4'd0;
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic test_none;
      @(negedge clk_in);
      ex_mem_op = 4'd0; ex_reg_addr = 5'd5; ex_reg_data = 32'h1234; ex_if_write = 1'b1;
      #1;
      checks++; if (mem_reg_addr_out !== 5'd5) begin errors++; $display("FAIL none_rd got=%0d exp=5", mem_reg_addr_out); end
      checks++; if (mem_reg_data_out !== 32'h1234) begin errors++; $display("FAIL none_data got=%h exp=00001234", mem_reg_data_out); end
      checks++; if (stall_req !== 1'b0 || if_write_out !== 1'b1) begin errors++; $display("FAIL none_ctl got stall=%0b wr=%0b exp 0/1", stall_req, if_write_out); end
`ifdef MEM_FWD_EN
      checks++; if (fwd_valid !== 1'b1 || fwd_reg_data !== 32'h1234) begin errors++; $display("FAIL none_fwd got=%0b/%h exp=1/00001234", fwd_valid, fwd_reg_data); end
`endif
      // Reserved op code behaves as NONE
      ex_mem_op = 4'd11; ex_reg_data = 32'hCAFE;
      #1;
      checks++; if (stall_req !== 1'b0 || mem_reg_data_out !== 32'hCAFE) begin errors++; $display("FAIL none_op11 got stall=%0b data=%h exp 0/0000cafe", stall_req, mem_reg_data_out); end
      ex_mem_op = 4'd0; ex_if_write = 1'b0;
   endtask

   task automatic test_lw;
      int cyc;
      int base;
      base = addr_log.size();
      @(negedge clk_in);
      ex_mem_op = 4'd3; ex_mem_addr = 32'h100; ex_reg_addr = 5'd10; ex_if_write = 1'b1; mem_gnt = 1'b1;
      #1;
      checks++; if (stall_req !== 1'b1 || if_write_out !== 1'b0) begin errors++; $display("FAIL lw_c0 got stall=%0b wr=%0b exp 1/0", stall_req, if_write_out); end
      run_until_done(0, cyc);
      checks++; if (cyc != 6) begin errors++; $display("FAIL lw_latency got=%0d exp=6", cyc); end
      checks++; if (mem_reg_data_out !== 32'h44332211) begin errors++; $display("FAIL lw_data got=%h exp=44332211", mem_reg_data_out); end
      checks++; if (mem_reg_addr_out !== 5'd10 || if_write_out !== 1'b1) begin errors++; $display("FAIL lw_wb got=%0d/%0b exp=10/1", mem_reg_addr_out, if_write_out); end
      checks++; if (addr_log.size() - base != 4) begin errors++; $display("FAIL lw_nreq got=%0d exp=4", addr_log.size() - base); end
      for (int i = 0; i < 4 && base + i < addr_log.size(); i++) begin
         checks++; if (addr_log[base+i] !== 32'h100 + i) begin errors++; $display("FAIL lw_addr%0d got=%h exp=%h", i, addr_log[base+i], 32'h100 + i); end
      end
      ex_mem_op = 4'd0; ex_if_write = 1'b0;
   endtask

   task automatic test_byte_half;
      logic [3:0]  ops  [3] = '{4'd1, 4'd4, 4'd2};
      logic [31:0] adrs [3] = '{32'h200, 32'h200, 32'h201};
      logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9234};
      int          lats [3] = '{3, 3, 4};
      int cyc;
      int base;
      for (int t = 0; t < 3; t++) begin
         base = addr_log.size();
         @(negedge clk_in);
         ex_mem_op = ops[t]; ex_mem_addr = adrs[t]; ex_reg_addr = 5'd4; ex_if_write = 1'b1;
         run_until_done(0, cyc);
         checks++; if (cyc != lats[t]) begin errors++; $display("FAIL bh%0d_latency got=%0d exp=%0d", t, cyc, lats[t]); end
         checks++; if (mem_reg_data_out !== exps[t]) begin errors++; $display("FAIL bh%0d_data got=%h exp=%h", t, mem_reg_data_out, exps[t]); end
         checks++; if (addr_log.size() <= base || addr_log[base] !== adrs[t]) begin errors++; $display("FAIL bh%0d_addr nreq=%0d exp first addr %h", t, addr_log.size() - base, adrs[t]); end
         ex_mem_op = 4'd0; ex_if_write = 1'b0;
      end
   endtask

   task automatic test_store_wait;
      int cyc;
      int abase;
      int wbase;
      abase = addr_log.size(); wbase = wdata_log.size();
      @(negedge clk_in);
      ex_mem_op = 4'd7; ex_mem_addr = 32'h300; ex_store_data = 32'h1234BEEF;
      ex_reg_addr = 5'd3; ex_if_write = 1'b1; mem_gnt = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk_in); #1;
         checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 8'hEF) begin
            errors++; $display("FAIL sh_hold%0d got req=%0b wr=%0b addr=%h wdata=%h exp 1/1/300/ef", c, mem_req, mem_wr, mem_addr, mem_wdata); end
      end
      @(negedge clk_in);
      mem_gnt = 1'b1;
      run_until_done(3, cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL sh_latency got=%0d exp=5", cyc); end
      checks++; if (if_write_out !== 1'b0) begin errors++; $display("FAIL sh_ifwrite got=%0b exp=0", if_write_out); end
      checks++; if (wdata_log.size() - wbase != 2) begin errors++; $display("FAIL sh_nwrites got=%0d exp=2", wdata_log.size() - wbase); end
      else begin
         checks++; if (wdata_log[wbase] !== 8'hEF || wdata_log[wbase+1] !== 8'hBE) begin errors++; $display("FAIL sh_bytes got=%h %h exp=ef be", wdata_log[wbase], wdata_log[wbase+1]); end
         checks++; if (addr_log[abase] !== 32'h300 || addr_log[abase+1] !== 32'h301) begin errors++; $display("FAIL sh_addrs got=%h %h exp=300 301", addr_log[abase], addr_log[abase+1]); end
      end
      ex_mem_op = 4'd0; ex_if_write = 1'b0;
   endtask

   task automatic test_rdy_freeze;
      int cyc;
      int base;
      base = addr_log.size();
      @(negedge clk_in);
      ex_mem_op = 4'd3; ex_mem_addr = 32'h100; ex_reg_addr = 5'd12; ex_if_write = 1'b1;
      @(negedge clk_in); #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rdy_c1_req got=%0b exp=1", mem_req); end
      @(negedge clk_in);
      rdy_in = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         if (c > 2) @(negedge clk_in);
         #1;
         checks++; if (mem_req !== 1'b0 || stall_req !== 1'b1) begin errors++; $display("FAIL rdy_low%0d got req=%0b stall=%0b exp 0/1", c, mem_req, stall_req); end
      end
      @(negedge clk_in);
      rdy_in = 1'b1;
      #1;
      checks++; if (mem_addr !== 32'h101 || mem_req !== 1'b1) begin errors++; $display("FAIL rdy_resume got addr=%h req=%0b exp 101/1", mem_addr, mem_req); end
      run_until_done(5, cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL rdy_latency got=%0d exp=9", cyc); end
      checks++; if (mem_reg_data_out !== 32'h44332211) begin errors++; $display("FAIL rdy_data got=%h exp=44332211", mem_reg_data_out); end
      checks++; if (addr_log.size() - base != 4) begin errors++; $display("FAIL rdy_nreq got=%0d exp=4", addr_log.size() - base); end
`ifdef MEM_FWD_EN
      checks++; if (fwd_valid !== 1'b1 || fwd_reg_addr !== 5'd12) begin errors++; $display("FAIL rdy_fwd_done got=%0b/%0d exp=1/12", fwd_valid, fwd_reg_addr); end
`endif
      ex_mem_op = 4'd0; ex_if_write = 1'b0;
      @(negedge clk_in); #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rdy_after_stall got=%0b exp=0", stall_req); end
`ifdef MEM_FWD_EN
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rdy_fwd_after got=%0b exp=0", fwd_valid); end
`endif
   endtask

   task automatic test_reset_mid_access;
      int req_before;
      @(negedge clk_in);
      ex_mem_op = 4'd3; ex_mem_addr = 32'h100; ex_reg_addr = 5'd9; ex_if_write = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1; ex_mem_op = 4'd0; ex_reg_data = 32'hABCD;
      #1;
      checks++; if (mem_req !== 1'b0 || stall_req !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL rstmid_mem got req=%0b stall=%0b addr=%h exp 0/0/0", mem_req, stall_req, mem_addr); end
      checks++; if (mem_reg_data_out !== 32'd0 || if_write_out !== 1'b0 || mem_reg_addr_out !== 5'd0) begin errors++; $display("FAIL rstmid_wb got=%h/%0b/%0d exp 0/0/0", mem_reg_data_out, if_write_out, mem_reg_addr_out); end
      req_before = req_count;
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      #1;
      checks++; if (req_count != req_before) begin errors++; $display("FAIL rstmid_noreq got=%0d exp=%0d", req_count, req_before); end
      checks++; if (stall_req !== 1'b0 || mem_reg_data_out !== 32'hABCD) begin errors++; $display("FAIL rstmid_idle got stall=%0b data=%h exp 0/0000abcd", stall_req, mem_reg_data_out); end
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; mem_gnt = 1'b0;
      ex_reg_addr = 5'd0; ex_reg_data = 32'd0; ex_if_write = 1'b0;
      ex_mem_op = 4'd0; ex_mem_addr = 32'd0; ex_store_data = 32'd0;
      for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
      mem_model[10'h100] = 8'h11; mem_model[10'h101] = 8'h22;
      mem_model[10'h102] = 8'h33; mem_model[10'h103] = 8'h44;
      mem_model[10'h200] = 8'h80; mem_model[10'h201] = 8'h34; mem_model[10'h202] = 8'h92;

      test_reset;
      test_none;
      test_lw;
      test_byte_half;
      test_store_wait;
      test_rdy_freeze;
      test_reset_mid_access;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
